add_mult_ctrl: RTL and testbench
================================

ADD_MULT_CTRL -- requirements
Module: add_mult_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, request a multiply; sampled only in IDLE.
REQ-004 SHALL have port a_in, input, 8, multiplicand (unsigned); captured on accepted start.
REQ-005 SHALL have port b_in, input, 8, multiplier (unsigned); captured on accepted start.
REQ-006 SHALL have port busy, output, 1, high from accepted start until done.
REQ-007 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-008 SHALL have port clear_p, output, 1, clears the downstream 16-bit product register.
REQ-009 SHALL have port load_p, output, 1, loads data_p into the downstream product register.
REQ-010 SHALL have port data_p, output, 16, running partial product for the product register.
REQ-011 SHALL have one clock; reset is asynchronous and active-low; ports named clk and rst_n.

Function
REQ-012 SHALL implement states IDLE, RUN; all outputs registered, none combinational from inputs.
REQ-013 SHALL, on an edge in IDLE with start=1: latch a_r=a_in, cnt=b_in, acc=0, data_p=0, clear_p=1, busy=1, done=0, go RUN.
REQ-014 SHALL, in IDLE with start=0: hold acc/data_p, clear_p=0, load_p=0, done=0.
REQ-015 SHALL, on each RUN edge with cnt!=0: acc=acc+a_r, cnt=cnt-1, data_p=acc+a_r, load_p=1, clear_p=0.
REQ-016 SHALL, on the RUN edge with cnt==0: load_p=0, clear_p=0, busy=0, done=1, go IDLE.
REQ-017 SHALL raise done exactly (counter operand)+2 edges after the start edge; done lasts one cycle.
REQ-018 SHALL perform 16-bit unsigned add; max 255*255=65025, no overflow path required.
REQ-019 SHALL ignore start while busy=1; operands unaffected by a_in/b_in changes during RUN.
REQ-020 SHALL accept start in the cycle done=1 (state already IDLE); done then drops next edge.
REQ-021 SHALL, for counter operand 0: no load_p pulse; done two edges after start; product register left cleared.
REQ-022 SHALL, for a_in=0 with nonzero counter: issue load_p pulses with data_p=0 each.
REQ-023 SHALL never assert clear_p and load_p in the same cycle.

Reset
REQ-024 SHALL, on rst_n=0 (any time, incl. mid-RUN): state=IDLE, acc=0, cnt=0, a_r=0, data_p=0, busy=0, done=0, load_p=0, clear_p=0.
REQ-025 SHALL resume normal start acceptance on the first rising clk edge after rst_n deasserts.

Configuration
REQ-026 SHALL support macro ADD_MULT_OPERAND_SWAP_EN.
REQ-027 SHALL, with ADD_MULT_OPERAND_SWAP_EN defined: on accepted start, a_r=max(a_in,b_in), cnt=min(a_in,b_in); latency min+2.
REQ-028 SHALL, without ADD_MULT_OPERAND_SWAP_EN: a_r=a_in, cnt=b_in always; latency b_in+2.

Verification
REQ-029 SHALL cover a_in=3, b_in=4 -> clear_p 1 cycle after start edge; load_p 4 cycles, data_p 3,6,9,12; done next cycle; busy low with done.
REQ-030 SHALL cover a_in=200, b_in=0 -> clear_p once, no load_p, done 2 edges after start, data_p=0.
REQ-031 SHALL cover a_in=255, b_in=255 (swap off) -> 255 load_p pulses, final data_p=16'hFE01, done at edge 257.
REQ-032 SHALL cover rst_n=0 after 3rd load_p of 5*9 -> all outputs 0 immediately; new start 2*2 gives data_p 2,4, done.
REQ-033 SHALL cover start held high through RUN and again in done cycle -> no restart mid-run; second op accepted on done cycle.
REQ-034 SHALL cover a_in=2, b_in=50 with ADD_MULT_OPERAND_SWAP_EN -> 2 load_p pulses data_p 50,100; done at edge 4.

Source files
------------

// File: rtl/add_mult_ctrl.sv
// Shift-free add-and-count multiplier controller: drives clear/load/data for a downstream
// product register. Optional define ADD_MULT_OPERAND_SWAP_EN counts down the smaller operand.
`timescale 1ns / 1ps

module add_mult_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  a_in,
   input  logic [7:0]  b_in,
   output logic        busy,
   output logic        done,
   output logic        clear_p,
   output logic        load_p,
   output logic [15:0] data_p
);

   typedef enum logic {StIdle, StRun} state_e;

   state_e      state_q, state_d;
   logic [7:0]  a_q, a_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] acc_q, acc_d;
   logic [15:0] data_p_q, data_p_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        clear_p_q, clear_p_d;
   logic        load_p_q, load_p_d;

   logic [7:0]  op_a;
   logic [7:0]  op_cnt;
   logic [15:0] acc_sum;

`ifdef ADD_MULT_OPERAND_SWAP_EN
   // Count down the smaller operand to shorten latency.
   assign op_a   = (a_in >= b_in) ? a_in : b_in;
   assign op_cnt = (a_in >= b_in) ? b_in : a_in;
`else
   assign op_a   = a_in;
   assign op_cnt = b_in;
`endif

   assign acc_sum = acc_q + {8'h00, a_q};

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      data_p_d  = data_p_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      clear_p_d = 1'b0;
      load_p_d  = 1'b0;

      case (state_q)
         StIdle: begin
            if (start) begin
               a_d       = op_a;
               cnt_d     = op_cnt;
               acc_d     = 16'h0000;
               data_p_d  = 16'h0000;
               clear_p_d = 1'b1;
               busy_d    = 1'b1;
               state_d   = StRun;
            end
         end
         StRun: begin
            if (cnt_q != 8'd0) begin
               acc_d    = acc_sum;
               data_p_d = acc_sum;
               cnt_d    = cnt_q - 8'd1;
               load_p_d = 1'b1;
            end else begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         a_q       <= 8'h00;
         cnt_q     <= 8'h00;
         acc_q     <= 16'h0000;
         data_p_q  <= 16'h0000;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         clear_p_q <= 1'b0;
         load_p_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         data_p_q  <= data_p_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         clear_p_q <= clear_p_d;
         load_p_q  <= load_p_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign clear_p = clear_p_q;
   assign load_p  = load_p_q;
   assign data_p  = data_p_q;

`ifndef SYNTHESIS
   // Clear and load target the same register; both at once would be ambiguous.
   a_clear_load_excl: assert property (@(posedge clk) disable iff (!rst_n)
      !(clear_p_q && load_p_q));
`endif

endmodule

// File: tb/tb_add_mult_ctrl.sv
// Directed self-checking bench for add_mult_ctrl; expectations follow the active
// ADD_MULT_OPERAND_SWAP_EN setting.
`timescale 1ns / 1ps

module tb_add_mult_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  a_in;
   logic [7:0]  b_in;
   logic        busy;
   logic        done;
   logic        clear_p;
   logic        load_p;
   logic [15:0] data_p;

   int total = 0;
   int bad   = 0;

   logic [15:0] lp_q[$];
   int n_clear, clear_edge, both_err, busy_err, done_edge;

   always #5 clk = ~clk;

   add_mult_ctrl dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a_in    (a_in),
      .b_in    (b_in),
      .busy    (busy),
      .done    (done),
      .clear_p (clear_p),
      .load_p  (load_p),
      .data_p  (data_p)
   );

   // Launches one operation and records what happens edge by edge until done or budget.
   // Operand inputs are scrambled after acceptance to show they are not re-sampled.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int budget);
      lp_q.delete();
      n_clear = 0; clear_edge = -1; both_err = 0; busy_err = 0; done_edge = -1;
      @(negedge clk);
      start = 1'b1; a_in = a; b_in = b;
      for (int e = 1; e <= budget; e++) begin
         @(posedge clk); #1;
         if (e == 1) begin
            start = 1'b0; a_in = ~a; b_in = ~b;
         end
         if (clear_p) begin
            n_clear++;
            if (clear_edge < 0) clear_edge = e;
         end
         if (load_p) lp_q.push_back(data_p);
         if (clear_p && load_p) both_err++;
         if (done) begin
            if (busy !== 1'b0) busy_err++;
            done_edge = e;
            break;
         end else if (busy !== 1'b1) begin
            busy_err++;
         end
      end
   endtask

   task automatic test_reset();
      logic [19:0] obs;
      rst_n = 1'b0; start = 1'b1; a_in = 8'd7; b_in = 8'd7;
      #12;
      obs = {busy, done, clear_p, load_p, data_p};
      total++;
      if (obs !== 20'h0) begin
         bad++; $display("FAIL reset_outputs got=%h want=%h", obs, 20'h0);
      end
      @(posedge clk); #1;
      obs = {busy, done, clear_p, load_p, data_p};
      total++;
      if (obs !== 20'h0) begin
         bad++; $display("FAIL reset_ignores_start got=%h want=%h", obs, 20'h0);
      end
      // Start is already high when reset releases: first edge must accept it.
      @(negedge clk);
      rst_n = 1'b1; a_in = 8'd1; b_in = 8'd1;
      @(posedge clk); #1;
      start = 1'b0;
      total++;
      if ({busy, clear_p} !== 2'b11) begin
         bad++; $display("FAIL reset_first_accept got=%b want=%b", {busy, clear_p}, 2'b11);
      end
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({done, data_p} !== {1'b1, 16'd1}) begin
         bad++; $display("FAIL reset_first_op got=%h want=%h", {done, data_p}, {1'b1, 16'd1});
      end
   endtask

   task automatic test_basic();
      logic [15:0] exp_d[4] = '{16'd3, 16'd6, 16'd9, 16'd12};
      logic [15:0] got;
      do_op(8'd3, 8'd4, 20);
      total++;
      if (done_edge !== 6) begin
         bad++; $display("FAIL basic_done_edge got=%0d want=6", done_edge);
      end
      total++;
      if (clear_edge !== 1 || n_clear !== 1) begin
         bad++; $display("FAIL basic_clear got=edge%0d/n%0d want=edge1/n1", clear_edge, n_clear);
      end
      total++;
      if (lp_q.size() !== 4) begin
         bad++; $display("FAIL basic_loads got=%0d want=4", lp_q.size());
      end
      for (int i = 0; i < 4; i++) begin
         got = (i < lp_q.size()) ? lp_q[i] : 16'hxxxx;
         total++;
         if (got !== exp_d[i]) begin
            bad++; $display("FAIL basic_data%0d got=%0d want=%0d", i, got, exp_d[i]);
         end
      end
      total++;
      if (busy_err !== 0 || both_err !== 0) begin
         bad++; $display("FAIL basic_busy_excl got=%0d/%0d want=0/0", busy_err, both_err);
      end
      @(posedge clk); #1;
      total++;
      if ({done, busy, data_p} !== {2'b00, 16'd12}) begin
         bad++; $display("FAIL basic_after_done got=%h want=%h", {done, busy, data_p},
                         {2'b00, 16'd12});
      end
   endtask

   task automatic test_zero_count();
      do_op(8'd200, 8'd0, 10);
      total++;
      if (done_edge !== 2) begin
         bad++; $display("FAIL zero_done_edge got=%0d want=2", done_edge);
      end
      total++;
      if (n_clear !== 1 || lp_q.size() !== 0) begin
         bad++; $display("FAIL zero_pulses got=clr%0d/ld%0d want=clr1/ld0", n_clear, lp_q.size());
      end
      @(posedge clk); #1;
      total++;
      if (data_p !== 16'd0) begin
         bad++; $display("FAIL zero_data got=%0d want=0", data_p);
      end
   endtask

   task automatic test_max();
      logic [15:0] last;
      do_op(8'd255, 8'd255, 300);
      last = (lp_q.size() > 0) ? lp_q[lp_q.size() - 1] : 16'hxxxx;
      total++;
      if (done_edge !== 257) begin
         bad++; $display("FAIL max_done_edge got=%0d want=257", done_edge);
      end
      total++;
      if (lp_q.size() !== 255) begin
         bad++; $display("FAIL max_loads got=%0d want=255", lp_q.size());
      end
      total++;
      if (last !== 16'hFE01) begin
         bad++; $display("FAIL max_final got=%h want=fe01", last);
      end
      total++;
      if (busy_err !== 0 || both_err !== 0) begin
         bad++; $display("FAIL max_busy_excl got=%0d/%0d want=0/0", busy_err, both_err);
      end
   endtask

   task automatic test_a_zero();
      int nz = 0;
      int exp_n, exp_done;
`ifdef ADD_MULT_OPERAND_SWAP_EN
      exp_n = 0; exp_done = 2;
`else
      exp_n = 5; exp_done = 7;
`endif
      do_op(8'd0, 8'd5, 20);
      foreach (lp_q[i]) if (lp_q[i] != 16'd0) nz++;
      total++;
      if (lp_q.size() !== exp_n || nz !== 0) begin
         bad++; $display("FAIL azero_loads got=%0d/nz%0d want=%0d/nz0", lp_q.size(), nz, exp_n);
      end
      total++;
      if (done_edge !== exp_done) begin
         bad++; $display("FAIL azero_done_edge got=%0d want=%0d", done_edge, exp_done);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      logic [19:0] obs;
      @(negedge clk);
      start = 1'b1; a_in = 8'd5; b_in = 8'd9;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (load_p) n++;
         if (n == 3) break;
      end
      total++;
      if (n !== 3) begin
         bad++; $display("FAIL rmid_reach got=%0d want=3", n);
      end
      rst_n = 1'b0;
      #1;
      obs = {busy, done, clear_p, load_p, data_p};
      total++;
      if (obs !== 20'h0) begin
         bad++; $display("FAIL rmid_outputs got=%h want=%h", obs, 20'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_op(8'd2, 8'd2, 10);
      total++;
      if (lp_q.size() !== 2 || done_edge !== 4) begin
         bad++; $display("FAIL rmid_op got=ld%0d/done%0d want=ld2/done4", lp_q.size(), done_edge);
      end
      total++;
      if (lp_q.size() == 2 && (lp_q[0] !== 16'd2 || lp_q[1] !== 16'd4)) begin
         bad++; $display("FAIL rmid_data got=%0d,%0d want=2,4", lp_q[0], lp_q[1]);
      end
   endtask

   task automatic test_back_to_back();
      logic [19:0] exp_o[7] = '{
         {4'b1010, 16'd0}, {4'b1001, 16'd3}, {4'b1001, 16'd6}, {4'b0100, 16'd6},
         {4'b1010, 16'd0}, {4'b1001, 16'd4}, {4'b0100, 16'd4}};
      logic [19:0] obs;
      @(negedge clk);
      start = 1'b1; a_in = 8'd3; b_in = 8'd2;
      for (int e = 1; e <= 7; e++) begin
         @(posedge clk); #1;
         obs = {busy, done, clear_p, load_p, data_p};
         total++;
         if (obs !== exp_o[e - 1]) begin
            bad++; $display("FAIL b2b_edge%0d got=%h want=%h", e, obs, exp_o[e - 1]);
         end
         if (e == 2) begin a_in = 8'd9; b_in = 8'd9; end
         if (e == 4) begin a_in = 8'd4; b_in = 8'd1; end
         if (e == 5) start = 1'b0;
      end
   endtask

   task automatic test_operand_order();
      int exp_n, exp_done;
      logic [15:0] exp0, expl, got0, gotl;
`ifdef ADD_MULT_OPERAND_SWAP_EN
      exp_n = 2; exp_done = 4; exp0 = 16'd50; expl = 16'd100;
`else
      exp_n = 50; exp_done = 52; exp0 = 16'd2; expl = 16'd100;
`endif
      do_op(8'd2, 8'd50, 70);
      got0 = (lp_q.size() > 0) ? lp_q[0] : 16'hxxxx;
      gotl = (lp_q.size() > 0) ? lp_q[lp_q.size() - 1] : 16'hxxxx;
      total++;
      if (lp_q.size() !== exp_n || done_edge !== exp_done) begin
         bad++; $display("FAIL order_timing got=ld%0d/done%0d want=ld%0d/done%0d",
                         lp_q.size(), done_edge, exp_n, exp_done);
      end
      total++;
      if (got0 !== exp0 || gotl !== expl) begin
         bad++; $display("FAIL order_data got=%0d..%0d want=%0d..%0d", got0, gotl, exp0, expl);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; a_in = 8'd0; b_in = 8'd0;
      test_reset();
      test_basic();
      test_zero_count();
      test_max();
      test_a_zero();
      test_reset_mid();
      test_back_to_back();
      test_operand_order();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
